// File: rtl/minefield_ctrl.sv
// Minefield for the tank game: one LFSR-placed mine per row, pixel contact
// against player sprites, explosions committed once per frame at vsync.
module minefield_ctrl #(
    parameter int          ROWS         = 16,
    parameter int          COLS         = 12,
    parameter int          X0           = 64,
    parameter int          Y0           = 48,
    parameter int          NUM_PLAYERS  = 2,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8:0]             hpos,
    input  logic [8:0]             vpos,
    input  logic                   vsync,
    input  logic [NUM_PLAYERS-1:0] player_gfx,
    input  logic                   rearm,
    output logic                   mine_gfx,
    output logic [NUM_PLAYERS-1:0] hit,
    output logic [4:0]             mines_left,
    output logic                   all_clear,
    output logic                   flash
);

    localparam logic [0:0] ARMING = 1'b0;
    localparam logic [0:0] PLAY   = 1'b1;

    logic [0:0]             state;
    logic [3:0]             r_cnt;
    logic [15:0]            lfsr;
    logic [3:0]             xpos [16];
    logic [15:0]            exploded;
    logic [15:0]            row_mask;
    logic [NUM_PLAYERS-1:0] hit_pend;
    logic [3:0]             flash_cnt;
    logic                   vs_q;

    logic [8:0]             dxs;
    logic [8:0]             dys;
    logic [3:0]             row;
    logic                   in_x;
    logic                   in_y;
    logic                   pat;
    logic                   mine_pix;
    logic [NUM_PLAYERS-1:0] contact;
    logic [15:0]            row_hot;
    logic                   vs_rise;
    logic [3:0]             v_mod;
    logic [15:0]            newly;

    function automatic logic [4:0] popcnt(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++)
            n = n + 5'(v[i]);
        return n;
    endfunction

    // Offsets wrap for pixels left of/above the window; the >= guards catch that.
    assign dxs  = (hpos - 9'(X0)) >> 3;
    assign dys  = (vpos - 9'(Y0)) >> 3;
    assign row  = dys[3:0];
    assign in_x = (hpos >= 9'(X0)) && (dxs < 9'(COLS));
    assign in_y = (vpos >= 9'(Y0)) && (dys < 9'(ROWS));
    assign pat  = (~(hpos[0] ^ hpos[1]) ^ (vpos[0] ^ vpos[1]))
                  & hpos[2] & vpos[2];

    assign mine_pix = in_x & in_y & pat
                      & (dxs == {5'b0, xpos[row]})
                      & ~exploded[row]
                      & (state == PLAY);

    assign mine_gfx  = mine_pix;
    assign contact   = player_gfx & {NUM_PLAYERS{mine_pix}};
    assign row_hot   = (|contact) ? (16'd1 << row) : 16'd0;
    assign vs_rise   = vsync & ~vs_q;
    assign newly     = row_mask & ~exploded;
    assign all_clear = (state == PLAY) && (mines_left == 5'd0);
    assign flash     = (flash_cnt != 4'd0);

    assign v_mod = ({1'b0, lfsr[3:0]} >= 5'(COLS))
                   ? lfsr[3:0] - 4'(COLS) : lfsr[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARMING;
            r_cnt      <= '0;
            lfsr       <= SEED;
            exploded   <= '0;
            row_mask   <= '0;
            hit_pend   <= '0;
            flash_cnt  <= '0;
            vs_q       <= 1'b0;
            hit        <= '0;
            mines_left <= '0;
            for (int i = 0; i < 16; i++)
                xpos[i] <= '0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            vs_q <= vsync;
            hit  <= '0;
            unique case (state)
                ARMING: begin
                    xpos[r_cnt]     <= v_mod;
                    exploded[r_cnt] <= 1'b0;
                    if (r_cnt == 4'(ROWS - 1)) begin
                        state      <= PLAY;
                        r_cnt      <= '0;
                        mines_left <= 5'(ROWS);
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                    if (vs_rise && flash_cnt != 4'd0)
                        flash_cnt <= flash_cnt - 4'd1;
                end
                PLAY: begin
                    if (rearm) begin
                        state     <= ARMING;
                        r_cnt     <= '0;
                        hit_pend  <= '0;
                        row_mask  <= '0;
                        flash_cnt <= '0;
                    end else begin
                        // Clear-then-set so a contact on the commit clock
                        // carries into the next frame.
                        hit_pend <= (vs_rise ? '0 : hit_pend) | contact;
                        row_mask <= (vs_rise ? 16'd0 : row_mask) | row_hot;
                        if (vs_rise) begin
                            exploded   <= exploded | row_mask;
                            hit        <= hit_pend;
                            mines_left <= mines_left - popcnt(newly);
                            if (|row_mask)
                                flash_cnt <= 4'(FLASH_FRAMES);
                            else if (flash_cnt != 4'd0)
                                flash_cnt <= flash_cnt - 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/minefield_ctrl.md
# minefield_ctrl

Parametrised, stateful minefield for the tank game. It draws one mine per horizontal row inside a configurable window, and places the mines pseudo-randomly each round from an internal LFSR. It detects pixel-level contact between live mines and up to NUM_PLAYERS sprite video signals, and commits explosions once per frame. It reports per-player hit pulses, a mines-remaining count, an all-clear flag and an explosion flash for the top-level mixer.

## Interface
- ROWS, 16: mine rows, 1..16; one mine per row.
- COLS, 12: cells per row, 8..16.
- X0, 64: window left edge, pixels.
- Y0, 48: window top edge, pixels.
- NUM_PLAYERS, 2: number of sprite inputs checked for contact.
- FLASH_FRAMES, 8: explosion flash duration in frames, 1..15.
- SEED, 16'hACE1: LFSR reset value; must be nonzero.
- clk  input  1  pixel clock.
- reset  input  1  asynchronous, active-low reset.
- hpos  input  9  current beam X.
- vpos  input  9  current beam Y.
- vsync  input  1  vertical sync from the sync generator.
- player_gfx  input  NUM_PLAYERS  per-player sprite video for the current pixel.
- rearm  input  1  level; starts a new round when sampled high in PLAY.
- mine_gfx  output  1  mine video, combinational from hpos/vpos and state.
- hit  output  NUM_PLAYERS  one-cycle pulse per player that struck a mine this frame.
- mines_left  output  5  live mine count.
- all_clear  output  1  high in PLAY when every mine has exploded.
- flash  output  1  high while the explosion flash counter is nonzero.

## Operation
- Cell geometry:
  - col = (hpos−X0)>>3 and row = (vpos−Y0)>>3.
  - in_window = X0 ≤ hpos < X0+8·COLS and Y0 ≤ vpos < Y0+8·ROWS.
- Mine pattern: pat = (~(hpos[0]^hpos[1]) ^ (vpos[0]^vpos[1])) & hpos[2] & vpos[2].
- Mine pixel: mine_pix = in_window & pat & (col == xpos[row]) & ~exploded[row] & (state == PLAY).
- mine_gfx = mine_pix.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Shifts every clock in all states.
  - Loads SEED on reset.
- State machine, two states: ARMING and PLAY.
  - ARMING: counter r runs 0..ROWS−1, one row per clock.
    - Each cycle: v = lfsr[3:0]; xpos[r] ← (v ≥ COLS) ? v−COLS : v.
    - Each cycle: exploded[r] ← 0.
    - After row ROWS−1: go to PLAY and set mines_left ← ROWS.
    - Pending state and the flash counter are cleared on entry.
  - PLAY:
    - rearm high → ARMING with r = 0.
    - rearm in ARMING is ignored.
- Contact, PLAY only: on each clock with mine_pix high, for each p with player_gfx[p] high:
  - hit_pend[p] ← 1.
  - row_mask[row] ← 1.
- Frame commit on the vsync rising edge (vsync high, registered vsync low), PLAY only:
  - exploded ← exploded | row_mask.
  - hit ← hit_pend for exactly one clock.
  - mines_left ← mines_left − popcount(row_mask & ~exploded).
  - If row_mask is nonzero, the flash counter loads FLASH_FRAMES.
  - hit_pend and row_mask are cleared.
- Flash counter: decrements on each vsync rising edge without a new load, saturating at 0; flash = counter ≠ 0.
- all_clear = (state == PLAY) & (mines_left == 0).

## Timing
- Reset values:
  - state ARMING, r = 0, xpos all 0, exploded all 0.
  - hit 0, mines_left 0, flash counter 0, all_clear 0.
  - mine_gfx 0 for the whole of ARMING.
- Arming latency: ROWS clocks after reset deassertion or after rearm is sampled; PLAY begins on the following clock.
- Contact to effect:
  - The hit pulse and mines_left update appear on the clock after the vsync rising edge is detected (registered-edge detect, 1-clock latency).
  - mine_gfx for an exploded mine drops from the next displayed frame.
- Same-cycle events:
  - Contact coinciding with a commit: clear-then-set; the new contact survives into the next frame's pending state.
  - rearm coinciding with a commit: rearm wins; no hit pulse, pending cleared, flash 0.
- Multiple contacts:
  - Repeated contact with one mine in a frame counts once.
  - Two players hitting the same mine in one frame both get hit pulses; mines_left drops by 1.
- Pixels outside the window or on exploded rows never register contact.
- Reset asserted mid-ARMING or mid-frame: all state returns to reset values immediately (asynchronous).

## Test plan
- Reset release with defaults:
  - mine_gfx = 0 for 16 clocks, then PLAY with mines_left = 16.
  - Each xpos < 12.
  - Exactly one mine cell is drawn per row within hpos 64..159 and vpos 48..175.
- player_gfx = 2'b01 held over one mine pixel of row 3:
  - At the next vsync rise, hit = 2'b01 for one clock and mines_left = 15.
  - Row 3 mine is absent next frame.
  - flash is high for exactly 8 frames.
- Players 0 and 1 hit different mines in one frame → hit = 2'b11 pulse and mines_left drops by 2. Same mine → hit = 2'b11 and mines_left drops by 1.
- player_gfx high on a pattern pixel outside the window, or on an exploded row → no hit, mines_left unchanged.
- rearm pulsed during flash with pending contact:
  - No hit pulse, flash = 0, 16 arming clocks.
  - mines_left = 16 and all mines redrawn.
- Clear all 16 mines over successive frames → all_clear = 1 after the final commit. A subsequent rearm drops all_clear on the next clock.
